csr_trap_ctrl: RTL and testbench
================================

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port trap_req  input  1  trap entry request, held by the requester until trap_ack.
REQ-004 SHALL have port trap_cause  input  32  mcause value; bit 31 = interrupt.
REQ-005 SHALL have ports trap_epc and trap_tval  input  32  faulting PC and mtval value.
REQ-006 SHALL have port mret_req  input  1  MRET request, held by the requester until mret_ack.
REQ-007 SHALL have ports trap_ack and mret_ack  output  1  one-cycle acceptance pulses.
REQ-008 SHALL have port instr_req  input  1  pipeline CSR-instruction write request.
REQ-009 SHALL have ports instr_addr (input, 12) and instr_wdata (input, 32)  CSR address and data for the pipeline write.
REQ-010 SHALL have port instr_gnt  output  1  pipeline write performed this cycle.
REQ-011 SHALL have ports csr_we (output, 1), csr_waddr (output, 12) and csr_wdata (output, 32)  CSR unit write port.
REQ-012 SHALL have ports csr_raddr (output, 12) and csr_rdata (input, 32)  CSR unit read port; csr_rdata is combinational, same cycle.
REQ-013 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, 32)  fetch redirect.
REQ-014 SHALL have port busy  output  1  high in every non-IDLE state.

Function
REQ-015 SHALL implement FSM states IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_REDIR, M_STATUS, M_REDIR.
REQ-016 SHALL use IDLE priority trap_req > mret_req > instr_req; at most one request is accepted per cycle.
REQ-017 SHALL, on trap acceptance in IDLE, pulse trap_ack, latch cause/epc/tval into registers, and go to T_EPC.
REQ-018 SHALL, in T_EPC, write latched epc with bits [1:0] forced to 0 to mepc (0x341).
REQ-019 SHALL, in T_CAUSE, write mcause (0x342); in T_TVAL, write mtval (0x343).
REQ-020 SHALL, in T_STATUS, read mstatus (0x300) and write it back with MPIE[7]=old MIE[3], MIE[3]=0, MPP[12:11]=2'b11, all other bits unchanged.
REQ-021 SHALL, in T_REDIR, read mtvec (0x305), pulse redirect_valid, and return to IDLE.
REQ-022 SHALL compute redirect_pc in T_REDIR as {base[31:2],2'b00}; when mode[1:0]=01 and latched cause[31]=1, it SHALL add 4*cause[30:0], truncated to 32 bits; mode 1x SHALL be treated as 00.
REQ-023 SHALL, on MRET acceptance, pulse mret_ack and go to M_STATUS.
REQ-024 SHALL, in M_STATUS, write mstatus with MIE=old MPIE, MPIE=1, MPP=2'b11 (M-only).
REQ-025 SHALL, in M_REDIR, read mepc (0x341), drive redirect_pc=mepc, pulse redirect_valid, and return to IDLE.
REQ-026 SHALL, for an instruction write, assert instr_gnt and csr_we combinationally in IDLE when instr_req=1 and no trap_req or mret_req is present, passing instr_addr and instr_wdata through.
REQ-027 SHALL keep instr_gnt=0 while busy, and SHALL ignore (not ack) trap_req and mret_req while busy; they are accepted on the first IDLE cycle.
REQ-028 SHALL set latency to trap_ack at cycle 0 and redirect_valid at cycle 5, and mret_ack at cycle 0 and redirect_valid at cycle 2.
REQ-029 SHALL keep csr_we=0 in IDLE without a grant, and in T_REDIR and M_REDIR.
REQ-030 SHALL drive csr_raddr=0 and csr_wdata=0 in states that do not use them.

Reset
REQ-031 SHALL, on rst=1, immediately enter IDLE and clear all latched registers, regardless of state.
REQ-032 SHALL hold all outputs at 0 during reset, and reset SHALL abort any in-flight sequence without issuing a redirect.

Structure
REQ-033 SHALL place the FSM state enum, the CSR addresses 0x300/0x305/0x341/0x342/0x343, and the mstatus bit positions MIE/MPIE/MPP in csr_pkg.
REQ-034 SHALL have no sub-module; the vector-address computation is inline combinational logic.

Verification
REQ-035 SHALL cover: exception trap (cause=2, epc=0x103, tval=0xDEAD, mtvec=0x8000_0000, mstatus MIE=1) -> writes mepc=0x100, mcause=2, mtval=0xDEAD, mstatus MIE=0/MPIE=1/MPP=11; redirect_pc=0x8000_0000 at cycle 5.
REQ-036 SHALL cover: interrupt cause=0x8000_0007 with mtvec=0x8000_0001 -> redirect_pc=0x8000_001C.
REQ-037 SHALL cover: MRET with mstatus MPIE=1, MIE=0, mepc=0x200 -> mstatus MIE=1/MPIE=1; redirect_pc=0x200 at cycle 2.
REQ-038 SHALL cover: trap_req, mret_req and instr_req all high in IDLE -> only trap_ack; instr_gnt=0 for cycles 0-5, then granted.
REQ-039 SHALL cover: rst asserted during T_CAUSE -> immediate IDLE, no further csr_we, no redirect_valid.
REQ-040 SHALL cover: instr_req alone (addr=0x340, data=0x55) -> same-cycle instr_gnt=1, csr_we=1, csr_waddr=0x340, csr_wdata=0x55.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap/MRET sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package csr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STATUS,
    T_REDIR,
    M_STATUS,
    M_REDIR
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Trap entry: stash MIE into MPIE, disable interrupts, previous mode = M.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] old);
    logic [31:0] v;
    v = old;
    v[MSTATUS_MPIE] = old[MSTATUS_MIE];
    v[MSTATUS_MIE]  = 1'b0;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

  // MRET: restore MIE from MPIE, set MPIE, this core only has M-mode.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] old);
    logic [31:0] v;
    v = old;
    v[MSTATUS_MIE]  = old[MSTATUS_MPIE];
    v[MSTATUS_MPIE] = 1'b1;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Sequences trap entry (mepc/mcause/mtval/mstatus writes + vector redirect) and MRET.
// Latency: ack in the request cycle; trap redirect 5 cycles later, MRET redirect 2 cycles later.
// Backpressure: requests are held by the requester; ignored while busy, pipeline writes granted only in idle.
module csr_trap_ctrl
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  output logic        trap_ack,
  output logic        mret_ack,
  input  logic        instr_req,
  input  logic [11:0] instr_addr,
  input  logic [31:0] instr_wdata,
  output logic        instr_gnt,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  state_e      state;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;
  logic [31:0] tvec_base;
  logic [31:0] tvec_off;
  logic [31:0] trap_target;

  // Sequencer state and trap context captured at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req) begin
            cause_q <= trap_cause;
            epc_q   <= trap_epc;
            tval_q  <= trap_tval;
            state   <= T_EPC;
          end else if (mret_req) begin
            state <= M_STATUS;
          end
        end
        T_EPC:    state <= T_CAUSE;
        T_CAUSE:  state <= T_TVAL;
        T_TVAL:   state <= T_STATUS;
        T_STATUS: state <= T_REDIR;
        T_REDIR:  state <= IDLE;
        M_STATUS: state <= M_REDIR;
        M_REDIR:  state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Vector target: vectored mode (01) offsets interrupts by 4*cause; modes 1x behave as direct.
  assign tvec_base   = csr_rdata & ~32'h3;
  assign tvec_off    = ((csr_rdata[1:0] == 2'b01) && cause_q[31]) ? {cause_q[29:0], 2'b00} : '0;
  assign trap_target = tvec_base + tvec_off;

  // Read address depends on state only, so the returned data never feeds back into it.
  always_comb begin
    csr_raddr = '0;
    if (!rst) begin
      case (state)
        T_STATUS, M_STATUS: csr_raddr = CSR_MSTATUS;
        T_REDIR:            csr_raddr = CSR_MTVEC;
        M_REDIR:            csr_raddr = CSR_MEPC;
        default:            csr_raddr = '0;
      endcase
    end
  end

  // Per-state output decode; everything is forced low while reset is asserted.
  always_comb begin
    trap_ack       = 1'b0;
    mret_ack       = 1'b0;
    instr_gnt      = 1'b0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          trap_ack = trap_req;
          mret_ack = mret_req && !trap_req;
          if (instr_req && !trap_req && !mret_req) begin
            instr_gnt = 1'b1;
            csr_we    = 1'b1;
            csr_waddr = instr_addr;
            csr_wdata = instr_wdata;
          end
        end
        T_EPC: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = epc_q & ~32'h3;
        end
        T_CAUSE: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MCAUSE;
          csr_wdata = cause_q;
        end
        T_TVAL: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MTVAL;
          csr_wdata = tval_q;
        end
        T_STATUS: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = trap_mstatus(csr_rdata);
        end
        T_REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = trap_target;
        end
        M_STATUS: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = mret_mstatus(csr_rdata);
        end
        M_REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = csr_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: CSR file model, scheduled request scenarios, reference model.
// Latency: n/a.
// Backpressure: requesters hold each request until its ack/grant is observed.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, mret_req, instr_req;
  logic [31:0] trap_cause, trap_epc, trap_tval;
  logic        trap_ack, mret_ack;
  logic [11:0] instr_addr;
  logic [31:0] instr_wdata;
  logic        instr_gnt;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  csr_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .mret_req(mret_req), .trap_ack(trap_ack), .mret_ack(mret_ack),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_wdata(instr_wdata), .instr_gnt(instr_gnt),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // CSR file seen by the DUT; the bench preloads it through its own port.
  logic [31:0] csr_mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) csr_mem[pl_addr] <= pl_data;
    else if (csr_we) csr_mem[csr_waddr] <= csr_wdata;
  end
  assign csr_rdata = csr_mem[csr_raddr];

  logic [31:0] ref_mem [0:4095];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Scenario description
  int          at, am, ai;
  logic [31:0] sc_cause, sc_epc, sc_tval, sc_idata;
  logic [11:0] sc_iaddr;

  // Observed and expected per-cycle events
  logic [31:0] r_tack [0:39], r_mack [0:39], r_gnt [0:39], r_rv [0:39], r_rpc [0:39], r_busy [0:39];
  logic [31:0] e_tack [0:39], e_mack [0:39], e_gnt [0:39], e_rv [0:39], e_rpc [0:39], e_busy [0:39];

  // Drive one scenario for n cycles; each requester holds until it sees acceptance.
  task automatic run_scn(input int n);
    bit td, md, idn;
    td = 0; md = 0; idn = 0;
    for (int c = 0; c < n; c++) begin
      trap_req    = (at >= 0) && (c >= at) && !td;
      mret_req    = (am >= 0) && (c >= am) && !md;
      instr_req   = (ai >= 0) && (c >= ai) && !idn;
      trap_cause  = sc_cause;
      trap_epc    = sc_epc;
      trap_tval   = sc_tval;
      instr_addr  = sc_iaddr;
      instr_wdata = sc_idata;
      @(negedge clk);
      r_tack[c] = {31'd0, trap_ack};
      r_mack[c] = {31'd0, mret_ack};
      r_gnt[c]  = {31'd0, instr_gnt};
      r_rv[c]   = {31'd0, redirect_valid};
      r_rpc[c]  = redirect_pc;
      r_busy[c] = {31'd0, busy};
      if (trap_ack) td = 1;
      if (mret_ack) md = 1;
      if (instr_gnt) idn = 1;
      @(posedge clk); #1;
    end
    trap_req = 0; mret_req = 0; instr_req = 0;
  endtask

  // Reference: one operation at a time, picked by priority whenever the unit is free;
  // each operation's architectural effect is applied as a whole.
  task automatic model_scn(input int n);
    int free_at;
    bit td, md, idn;
    logic [31:0] old, mt, pc;
    longint sum;
    free_at = 0; td = 0; md = 0; idn = 0;
    for (int k = 0; k < 40; k++) begin
      e_tack[k] = 0; e_mack[k] = 0; e_gnt[k] = 0; e_rv[k] = 0; e_rpc[k] = 0; e_busy[k] = 0;
    end
    for (int t = 0; t < n; t++) begin
      if (t < free_at) continue;
      if (at >= 0 && t >= at && !td) begin
        td = 1;
        e_tack[t] = 1;
        for (int k = 1; k <= 5; k++) e_busy[t + k] = 1;
        ref_mem[12'h341] = sc_epc - (sc_epc % 4);
        ref_mem[12'h342] = sc_cause;
        ref_mem[12'h343] = sc_tval;
        old = ref_mem[12'h300];
        ref_mem[12'h300] = (old & ~32'h0000_1888) | (((old >> 3) & 32'd1) << 7) | 32'h0000_1800;
        mt = ref_mem[12'h305];
        sum = longint'(mt - (mt % 4));
        if ((mt % 4) == 1 && sc_cause >= 32'h8000_0000)
          sum = sum + 4 * longint'(sc_cause - 32'h8000_0000);
        pc = sum[31:0];
        e_rv[t + 5]  = 1;
        e_rpc[t + 5] = pc;
        free_at = t + 6;
      end else if (am >= 0 && t >= am && !md) begin
        md = 1;
        e_mack[t] = 1;
        e_busy[t + 1] = 1;
        e_busy[t + 2] = 1;
        old = ref_mem[12'h300];
        ref_mem[12'h300] = (old & ~32'h0000_1888) | (((old >> 7) & 32'd1) << 3) | 32'h0000_1880;
        e_rv[t + 2]  = 1;
        e_rpc[t + 2] = ref_mem[12'h341];
        free_at = t + 3;
      end else if (ai >= 0 && t >= ai && !idn) begin
        idn = 1;
        e_gnt[t] = 1;
        ref_mem[sc_iaddr] = sc_idata;
        free_at = t + 1;
      end
    end
  endtask

  task automatic compare_scn(input string tag, input int n);
    logic [11:0] addrs [0:6];
    addrs[0] = 12'h000; addrs[1] = 12'h300; addrs[2] = 12'h305; addrs[3] = 12'h341;
    addrs[4] = 12'h342; addrs[5] = 12'h343; addrs[6] = sc_iaddr;
    for (int c = 0; c < n; c++) begin
      check($sformatf("%s.c%0d.trap_ack", tag, c), r_tack[c], e_tack[c]);
      check($sformatf("%s.c%0d.mret_ack", tag, c), r_mack[c], e_mack[c]);
      check($sformatf("%s.c%0d.instr_gnt", tag, c), r_gnt[c], e_gnt[c]);
      check($sformatf("%s.c%0d.redirect_valid", tag, c), r_rv[c], e_rv[c]);
      check($sformatf("%s.c%0d.busy", tag, c), r_busy[c], e_busy[c]);
      if (e_rv[c] == 1) check($sformatf("%s.c%0d.redirect_pc", tag, c), r_rpc[c], e_rpc[c]);
    end
    for (int k = 0; k < 7; k++)
      check($sformatf("%s.csr%03h", tag, addrs[k]), csr_mem[addrs[k]], ref_mem[addrs[k]]);
  endtask

  task automatic scenario(input string tag);
    model_scn(20);
    run_scn(20);
    compare_scn(tag, 20);
  endtask

  initial begin
    logic [31:0] v;
    int n_we, n_rv;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    for (int k = 0; k < 4096; k++) ref_mem[k] = 32'd0;

    // Reset with every request asserted: all outputs must stay low.
    rst = 1; trap_req = 1; mret_req = 1; instr_req = 1;
    trap_cause = 32'h3; trap_epc = 32'h10; trap_tval = 32'h1;
    instr_addr = 12'h340; instr_wdata = 32'h77;
    #2;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.trap_ack", {31'd0, trap_ack}, 32'd0);
    check("rst.mret_ack", {31'd0, mret_ack}, 32'd0);
    check("rst.instr_gnt", {31'd0, instr_gnt}, 32'd0);
    check("rst.csr_we", {31'd0, csr_we}, 32'd0);
    check("rst.csr_waddr", {20'd0, csr_waddr}, 32'd0);
    check("rst.csr_wdata", csr_wdata, 32'd0);
    check("rst.redirect_valid", {31'd0, redirect_valid}, 32'd0);
    @(posedge clk); #1;
    trap_req = 0; mret_req = 0; instr_req = 0;
    rst = 0;
    #1;
    check("idle.csr_raddr", {20'd0, csr_raddr}, 32'd0);
    check("idle.csr_we", {31'd0, csr_we}, 32'd0);
    @(posedge clk); #1;
    preload(12'h000, 32'h0); preload(12'h340, 32'h0);
    preload(12'h341, 32'h0); preload(12'h342, 32'h0); preload(12'h343, 32'h0);

    // Lone pipeline write: granted and passed through in the same cycle.
    instr_req = 1; instr_addr = 12'h340; instr_wdata = 32'h55;
    @(negedge clk);
    check("iw.instr_gnt", {31'd0, instr_gnt}, 32'd1);
    check("iw.csr_we", {31'd0, csr_we}, 32'd1);
    check("iw.csr_waddr", {20'd0, csr_waddr}, 32'h340);
    check("iw.csr_wdata", csr_wdata, 32'h55);
    check("iw.busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    instr_req = 0;
    ref_mem[12'h340] = 32'h55;
    check("iw.mem", csr_mem[12'h340], 32'h55);

    // Exception trap with direct mtvec.
    preload(12'h300, 32'h0000_0008); preload(12'h305, 32'h8000_0000);
    at = 0; am = -1; ai = -1;
    sc_cause = 32'd2; sc_epc = 32'h103; sc_tval = 32'hDEAD; sc_iaddr = 12'h000; sc_idata = 32'h0;
    scenario("exc");
    check("exc.ack0", r_tack[0], 32'd1);
    check("exc.rv5", r_rv[5], 32'd1);
    check("exc.pc5", r_rpc[5], 32'h8000_0000);
    check("exc.mepc", csr_mem[12'h341], 32'h100);
    check("exc.mcause", csr_mem[12'h342], 32'd2);
    check("exc.mtval", csr_mem[12'h343], 32'hDEAD);
    v = csr_mem[12'h300];
    check("exc.mstatus", {29'd0, v[3], v[12:11]} , {29'd0, 1'b0, 2'b11});
    check("exc.mpie", {31'd0, v[7]}, 32'd1);

    // Vectored interrupt.
    preload(12'h305, 32'h8000_0001);
    at = 0; am = -1; ai = -1;
    sc_cause = 32'h8000_0007; sc_epc = 32'h400; sc_tval = 32'h0;
    scenario("irq");
    check("irq.pc5", r_rpc[5], 32'h8000_001C);

    // MRET.
    preload(12'h300, 32'h0000_0080); preload(12'h341, 32'h200);
    at = -1; am = 0; ai = -1;
    scenario("mret");
    check("mret.rv2", r_rv[2], 32'd1);
    check("mret.pc2", r_rpc[2], 32'h200);
    v = csr_mem[12'h300];
    check("mret.mie_mpie", {30'd0, v[3], v[7]}, 32'd3);

    // All three requests at once.
    preload(12'h305, 32'h0000_1000);
    at = 0; am = 0; ai = 0;
    sc_cause = 32'd5; sc_epc = 32'h808; sc_tval = 32'h44; sc_iaddr = 12'h7C0; sc_idata = 32'hA5A5;
    scenario("all3");
    check("all3.mack0", r_mack[0], 32'd0);
    check("all3.gnt5", r_gnt[5], 32'd0);

    // Reset in the middle of trap entry.
    preload(12'h342, 32'h1111); preload(12'h343, 32'h2222);
    trap_req = 1; trap_cause = 32'd5; trap_epc = 32'h4447; trap_tval = 32'h9;
    @(negedge clk);
    check("rstmid.ack", {31'd0, trap_ack}, 32'd1);
    @(posedge clk); #1;
    trap_req = 0;
    @(posedge clk); #1;
    check("rstmid.we_cause", {31'd0, csr_we}, 32'd1);
    #2 rst = 1;
    #1;
    check("rstmid.busy", {31'd0, busy}, 32'd0);
    check("rstmid.we", {31'd0, csr_we}, 32'd0);
    check("rstmid.rv", {31'd0, redirect_valid}, 32'd0);
    @(negedge clk);
    rst = 0;
    n_we = 0; n_rv = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (csr_we) n_we++;
      if (redirect_valid) n_rv++;
    end
    @(posedge clk); #1;
    check("rstmid.n_we", n_we, 32'd0);
    check("rstmid.n_rv", n_rv, 32'd0);
    ref_mem[12'h341] = 32'h4444;
    check("rstmid.mepc", csr_mem[12'h341], 32'h4444);
    check("rstmid.mcause", csr_mem[12'h342], 32'h1111);
    check("rstmid.mtval", csr_mem[12'h343], 32'h2222);

    // Randomized request mixes.
    for (int s = 0; s < 25; s++) begin
      preload(12'h300, $urandom);
      preload(12'h305, $urandom);
      preload(12'h341, $urandom);
      at = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 4)) : -1;
      am = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 4)) : -1;
      ai = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 4)) : -1;
      sc_cause = $urandom;
      sc_epc   = $urandom;
      sc_tval  = $urandom;
      sc_iaddr = 12'($urandom_range(0, 4095));
      sc_idata = $urandom;
      scenario($sformatf("rnd%0d", s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
